// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer_if
// Description : Command stream, ALU port and response stream bundle for
//               alu_cmd_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if;
    // command stream
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_tag;

    // ALU drive and results
    logic [1:0] alu_S;
    logic [3:0] alu_A;
    logic [3:0] alu_B;
    logic [3:0] add_result;
    logic [3:0] sub_result;
    logic [3:0] and_result;
    logic       bit5;
    logic       sub_sign;
    logic       GT;
    logic       EQ;
    logic       LT;

    // response stream and status
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_data;
    logic [1:0] rsp_op;
    logic [3:0] rsp_tag;
    logic       busy;
    logic [7:0] done_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output alu_S, alu_A, alu_B,
        input  add_result, sub_result, and_result, bit5, sub_sign, GT, EQ, LT,
        output rsp_valid, rsp_data, rsp_op, rsp_tag,
        input  rsp_ready,
        output busy, done_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  alu_S, alu_A, alu_B,
        output add_result, sub_result, and_result, bit5, sub_sign, GT, EQ, LT,
        input  rsp_valid, rsp_data, rsp_op, rsp_tag,
        output rsp_ready,
        input  busy, done_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : 2-entry command FIFO feeding the 4-bit ALU; one packed,
//               tagged response per command over a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_cmd_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] tag;
    } cmd_t;

    localparam logic [1:0] c_FIFO_DEPTH = 2'd2;

    state_t     r_state;
    state_t     w_state_nxt;

    cmd_t       r_fifo [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic [1:0] r_alu_S;
    logic [3:0] r_alu_A;
    logic [3:0] r_alu_B;
    logic [3:0] r_tag;

    logic       r_rsp_valid;
    logic [4:0] r_rsp_data;
    logic [1:0] r_rsp_op;
    logic [3:0] r_rsp_tag;
    logic [7:0] r_done_count;

    logic       w_cmd_ready;
    logic       w_push;
    logic       w_pop;
    logic       w_capture;
    logic       w_retire;
    cmd_t       w_head;
    cmd_t       w_cmd_in;
    logic [4:0] w_rsp_pack;

    // Ready comes from the registered count only; a pop does not free a slot
    // for a push in the same cycle.
    assign w_cmd_ready = (r_count < c_FIFO_DEPTH);
    assign w_push      = bus.cmd_valid && w_cmd_ready;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_cmd_in    = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, tag: bus.cmd_tag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != 2'd0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The issued op lives in r_alu_S; it selects the packing at capture.
    always_comb begin
        w_rsp_pack = 5'd0;
        case (r_alu_S)
            2'b00:   w_rsp_pack = {bus.bit5, bus.add_result};
            2'b01:   w_rsp_pack = {bus.sub_sign, bus.sub_result};
            2'b10:   w_rsp_pack = {2'b00, bus.GT, bus.EQ, bus.LT};
            default: w_rsp_pack = {1'b0, bus.and_result};
        endcase
    end

    // Storage array carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_alu_S      <= 2'd0;
            r_alu_A      <= 4'd0;
            r_alu_B      <= 4'd0;
            r_tag        <= 4'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 5'd0;
            r_rsp_op     <= 2'd0;
            r_rsp_tag    <= 4'd0;
            r_done_count <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_alu_S  <= w_head.op;
                r_alu_A  <= w_head.a;
                r_alu_B  <= w_head.b;
                r_tag    <= w_head.tag;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_rsp_pack;
                r_rsp_op    <= r_alu_S;
                r_rsp_tag   <= r_tag;
            end else if (w_retire) begin
                r_rsp_valid  <= 1'b0;
                r_done_count <= r_done_count + 8'd1;
            end
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.alu_S      = r_alu_S;
    assign bus.alu_A      = r_alu_A;
    assign bus.alu_B      = r_alu_B;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_op     = r_rsp_op;
    assign bus.rsp_tag    = r_rsp_tag;
    assign bus.busy       = (r_state != ST_IDLE) || (r_count != 2'd0);
    assign bus.done_count = r_done_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Directed self-checking bench for alu_cmd_sequencer with a
//               behavioural 4-bit ALU on the alu_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // behavioural ALU
    assign {bus.bit5, bus.add_result} = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
    assign bus.sub_result = bus.alu_A - bus.alu_B;
    assign bus.sub_sign   = (bus.alu_A < bus.alu_B);
    assign bus.and_result = bus.alu_A & bus.alu_B;
    assign bus.GT         = (bus.alu_A > bus.alu_B);
    assign bus.EQ         = (bus.alu_A == bus.alu_B);
    assign bus.LT         = (bus.alu_A < bus.alu_B);

    function automatic logic [4:0] ref_rsp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = a - b;
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {(a < b), d};
            2'b10:   return {2'b00, (a > b), (a == b), (a < b)};
            default: return {1'b0, a & b};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] tag, output bit ok);
        bit acc;
        int n;
        ok = 1'b0;
        n  = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = tag;
        while (!ok && n < 40) begin
            acc = bus.cmd_ready;
            tick();
            n++;
            if (acc) ok = 1'b1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output bit ok);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < limit) begin
            tick();
            n++;
        end
        ok = bus.rsp_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b expected 1", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b expected 0", bus.rsp_valid); end
        checks++; if ({bus.rsp_data, bus.rsp_op, bus.rsp_tag} !== 11'd0) begin errors++; $display("FAIL reset_rsp_fields got %h expected 0", {bus.rsp_data, bus.rsp_op, bus.rsp_tag}); end
        checks++; if ({bus.alu_S, bus.alu_A, bus.alu_B} !== 10'd0) begin errors++; $display("FAIL reset_alu got %h expected 0", {bus.alu_S, bus.alu_A, bus.alu_B}); end
        checks++; if (bus.busy !== 1'b0 || bus.done_count !== 8'd0) begin errors++; $display("FAIL reset_status got busy %b count %0d expected 0 0", bus.busy, bus.done_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        bit ok;
        bus.rsp_ready = 1'b1;
        send_cmd(2'b00, 4'd4, 4'd10, 4'd3, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_accept got timeout expected accept"); end
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL add_t0 got valid %b busy %b expected 0 1", bus.rsp_valid, bus.busy); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_t1_valid got %b expected 0", bus.rsp_valid); end
        checks++; if ({bus.alu_S, bus.alu_A, bus.alu_B} !== {2'b00, 4'd4, 4'd10}) begin errors++; $display("FAIL add_issue_alu got %h expected %h", {bus.alu_S, bus.alu_A, bus.alu_B}, {2'b00, 4'd4, 4'd10}); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL add_t2_valid got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 5'b01110) begin errors++; $display("FAIL add_data got %b expected 01110", bus.rsp_data); end
        checks++; if (bus.rsp_tag !== 4'd3 || bus.rsp_op !== 2'b00) begin errors++; $display("FAIL add_tag_op got %h %h expected 3 0", bus.rsp_tag, bus.rsp_op); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_one_cycle got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.done_count !== 8'd1 || bus.busy !== 1'b0) begin errors++; $display("FAIL add_done got count %0d busy %b expected 1 0", bus.done_count, bus.busy); end
    endtask

    task automatic test_back_to_back();
        bit ok0, ok1, ok;
        int t_first, t_second;
        bus.rsp_ready = 1'b1;
        send_cmd(2'b00, 4'd15, 4'd15, 4'd1, ok0);
        send_cmd(2'b01, 4'd13, 4'd10, 4'd2, ok1);
        checks++; if (!(ok0 && ok1)) begin errors++; $display("FAIL b2b_accept got %b%b expected 11", ok0, ok1); end
        wait_rsp(10, ok);
        t_first = cyc;
        checks++; if (!ok || bus.rsp_data !== 5'b11110 || bus.rsp_tag !== 4'd1) begin errors++; $display("FAIL b2b_first got data %b tag %h expected 11110 1", bus.rsp_data, bus.rsp_tag); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b expected 0", bus.rsp_valid); end
        wait_rsp(10, ok);
        t_second = cyc;
        checks++; if (!ok || bus.rsp_data !== 5'b00011 || bus.rsp_tag !== 4'd2 || bus.rsp_op !== 2'b01) begin errors++; $display("FAIL b2b_second got data %b tag %h op %h expected 00011 2 1", bus.rsp_data, bus.rsp_tag, bus.rsp_op); end
        checks++; if (t_second - t_first !== 3) begin errors++; $display("FAIL b2b_spacing got %0d expected 3", t_second - t_first); end
        tick();
        checks++; if (bus.done_count !== 8'd3) begin errors++; $display("FAIL b2b_done got %0d expected 3", bus.done_count); end
    endtask

    task automatic test_cmp_and();
        logic [1:0] ops  [3] = '{2'b10, 2'b10, 2'b11};
        logic [3:0] as   [3] = '{4'd7, 4'd15, 4'd15};
        logic [3:0] bs   [3] = '{4'd1, 4'd15, 4'd12};
        logic [4:0] exps [3] = '{5'b00100, 5'b00010, 5'b01100};
        bit ok_s, ok_r;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_cmd(ops[i], as[i], bs[i], 4'(i + 4), ok_s);
            wait_rsp(10, ok_r);
            checks++;
            if (!ok_s || !ok_r || bus.rsp_data !== exps[i] || bus.rsp_tag !== 4'(i + 4)) begin
                errors++;
                $display("FAIL cmp_and_%0d got data %b tag %h expected %b %h", i, bus.rsp_data, bus.rsp_tag, exps[i], 4'(i + 4));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_tag  [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
        logic [4:0] exp_data [4] = '{5'b00011, 5'b11101, 5'b00001, 5'b00010};
        logic [3:0] got_tag  [4];
        logic [4:0] got_data [4];
        bit ok1, ok2, ok3, acc;
        int got, n;
        bus.rsp_ready = 1'b0;
        send_cmd(2'b00, 4'd1, 4'd2, 4'h8, ok1);
        send_cmd(2'b01, 4'd2, 4'd5, 4'h9, ok2);
        send_cmd(2'b10, 4'd3, 4'd9, 4'hA, ok3);
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL bp_accept got %b%b%b expected 111", ok1, ok2, ok3); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full got cmd_ready %b expected 0", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'h8) begin errors++; $display("FAIL bp_first_held got valid %b tag %h expected 1 8", bus.rsp_valid, bus.rsp_tag); end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        bus.cmd_a     = 4'd10;
        bus.cmd_b     = 4'd6;
        bus.cmd_tag   = 4'hB;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 5'b00011 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall_%0d got ready %b valid %b data %b busy %b expected 0 1 00011 1", i, bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.busy);
            end
        end
        bus.rsp_ready = 1'b1;
        got = 0;
        n   = 0;
        while (got < 4 && n < 60) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                got_tag[got]  = bus.rsp_tag;
                got_data[got] = bus.rsp_data;
                got++;
            end
            acc = bus.cmd_valid && bus.cmd_ready;
            tick();
            n++;
            if (acc) bus.cmd_valid = 1'b0;
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_count got %0d expected 4", got); end
        for (int i = 0; i < 4; i++) begin
            if (i < got) begin
                checks++;
                if (got_tag[i] !== exp_tag[i] || got_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL bp_rsp_%0d got tag %h data %b expected %h %b", i, got_tag[i], got_data[i], exp_tag[i], exp_data[i]);
                end
            end
        end
        bus.cmd_valid = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2, stale;
        bus.rsp_ready = 1'b0;
        send_cmd(2'b00, 4'd1, 4'd1, 4'd5, ok1);
        send_cmd(2'b00, 4'd2, 4'd2, 4'd6, ok2);
        tick();
        checks++; if (!(ok1 && ok2) || bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_setup got valid %b ready %b expected 1 1", bus.rsp_valid, bus.cmd_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || {bus.rsp_data, bus.rsp_op, bus.rsp_tag} !== 11'd0) begin errors++; $display("FAIL rmid_rsp got valid %b fields %h expected 0 0", bus.rsp_valid, {bus.rsp_data, bus.rsp_op, bus.rsp_tag}); end
        checks++; if ({bus.alu_S, bus.alu_A, bus.alu_B} !== 10'd0) begin errors++; $display("FAIL rmid_alu got %h expected 0", {bus.alu_S, bus.alu_A, bus.alu_B}); end
        checks++; if (bus.busy !== 1'b0 || bus.done_count !== 8'd0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_status got busy %b count %0d ready %b expected 0 0 1", bus.busy, bus.done_count, bus.cmd_ready); end
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.rsp_valid || bus.busy) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0 || bus.done_count !== 8'd0) begin errors++; $display("FAIL rmid_stale got stale %b count %0d expected 0 0", stale, bus.done_count); end
    endtask

    task automatic test_wrap();
        bit ok_s, ok_r;
        logic [7:0] v;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            send_cmd(v[1:0], v[3:0], v[7:4], v[5:2], ok_s);
            wait_rsp(10, ok_r);
            checks++;
            if (!ok_s || !ok_r || bus.rsp_data !== ref_rsp(v[1:0], v[3:0], v[7:4]) || bus.rsp_tag !== v[5:2]) begin
                errors++;
                $display("FAIL wrap_rsp_%0d got data %b tag %h expected %b %h", i, bus.rsp_data, bus.rsp_tag, ref_rsp(v[1:0], v[3:0], v[7:4]), v[5:2]);
            end
            tick();
            if (i == 254) begin
                checks++;
                if (bus.done_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d expected 255", bus.done_count); end
            end
        end
        checks++; if (bus.done_count !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d expected 0", bus.done_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wrap_busy got %b expected 0", bus.busy); end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 4'd0;
        bus.cmd_b     = 4'd0;
        bus.cmd_tag   = 4'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_cmp_and();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Sequential front end for the 4-bit combinational ALU. It accepts operation commands over a valid/ready stream and buffers them in a 2-entry FIFO. Each command is issued to the ALU select/operand ports, the ALU outputs are captured after one settle cycle, and one packed result per command is returned over a valid/ready response stream. It replaces bench-style direct driving of S/A/B and sits between a host/controller and the ALU instance.

## Interface

Parameters:
- none (widths fixed: 4-bit operands, 2-bit op, 4-bit tag, 8-bit completion counter)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept command
- cmd_op  in  2  00 add, 01 sub, 10 compare, 11 and
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_tag  in  4  opaque ID, returned with response
- alu_S  out  2  to ALU S
- alu_A  out  4  to ALU A
- alu_B  out  4  to ALU B
- add_result, sub_result, and_result  in  4 each  from ALU
- bit5, sub_sign, GT, EQ, LT  in  1 each  from ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  5  packed result
- rsp_op  out  2  op of this response
- rsp_tag  out  4  tag of this response
- busy  out  1  FSM not IDLE or FIFO non-empty
- done_count  out  8  completed responses, wraps

## Operation

- Command FIFO: 2 entries of {op, a, b, tag}. cmd_ready = (count < 2), derived from registered count only, with no pop-side bypass. Push on cmd_valid && cmd_ready. Order is strictly FIFO.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head at the clock edge, load alu_S/alu_A/alu_B plus internal op/tag registers, go to ISSUE. Otherwise stay.
  - ISSUE: one settle cycle. At the next edge, sample the ALU outputs into rsp_data, set rsp_op/rsp_tag, set rsp_valid = 1, go to RESP.
  - RESP: hold all rsp_* outputs stable while rsp_valid && !rsp_ready. On rsp_ready, clear rsp_valid, increment done_count, return to IDLE.
- rsp_data packing:
  - op 00: {bit5, add_result}
  - op 01: {sub_sign, sub_result}
  - op 10: {2'b00, GT, EQ, LT}
  - op 11: {1'b0, and_result}
- alu_S/A/B keep their last issued value until the next pop and do not change during ISSUE or RESP.
- A push and a pop in the same cycle are both performed, and the count is unchanged.
- done_count wraps 255 -> 0 with no flag.

## Timing

- Reset (async assert, sync release) sets:
  - cmd_ready = 1
  - rsp_valid = 0, rsp_data = 0, rsp_op = 0, rsp_tag = 0
  - alu_S = 0, alu_A = 0, alu_B = 0
  - busy = 0, done_count = 0
  - FIFO empty, FSM IDLE
- Reset mid-operation discards the FIFO contents and any in-flight response. No response is emitted for discarded commands.
- Latency with an empty FIFO, FSM in IDLE and command accepted at edge t0:
  - pop at t1
  - capture at t2, rsp_valid high after t2
- With rsp_ready held high, rsp_valid stays high for exactly one cycle.
- Throughput: one command per 3 cycles when rsp_ready is constantly high.
- Backpressure:
  - With rsp_ready low, the FSM stalls in RESP.
  - The FIFO still accepts commands until it holds 2, then cmd_ready drops.
  - cmd_ready rises the cycle after the next pop.
- cmd_* must be held stable by the producer only during a cycle with cmd_valid && !cmd_ready. No ordering rule is imposed beyond valid/ready.

## Test plan

- Single add: op 00, A=4, B=10, tag=3 -> rsp_valid after 2 edges post-accept, rsp_data=5'b01110, rsp_tag=3, done_count=1.
- Add with carry and sub back-to-back: (00, 15, 15) then (01, 13, 10), rsp_ready=1 -> responses in order, rsp_data 5'b11110 then 5'b00011. Responses are 3 cycles apart.
- Compare and AND: (10, 7, 1) -> 5'b00100 (GT). (10, 15, 15) -> 5'b00010 (EQ). (11, 15, 12) -> 5'b01100.
- Backpressure/full:
  - Setup: hold rsp_ready=0 and push 4 commands.
  - Expected: the first is captured, then 2 are queued and cmd_ready=0. The 4th waits.
  - Release rsp_ready: all 4 responses arrive in order with the correct tags.
- Reset mid-operation: assert rsp_n low while in RESP with the FIFO holding 1 entry -> all outputs return to reset values immediately. After release, no stale response appears and done_count=0.
- Counter wrap: 256 completed commands -> done_count returns to 0. busy=0 after the last one.
